sipo_rx: RTL and testbench
==========================

# sipo_rx

Serial-in, parallel-out receiver (deserializer) for the team's bit-serial links. It collects `WIDTH` qualified serial bits into a word and presents the word on a registered parallel output with a valid/ready handshake. Framing errors and overruns are reported on sticky flags. It sits at the receiving end of a link driven by a PISO serializer and feeds parallel datapath logic.

## Interface

Parameters:
- `WIDTH`, default 4: bits per word; legal range 2 to 32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `dout[WIDTH-1]`; 0 means it lands in `dout[0]`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `sin`  input  1  serial data bit.
- `sin_en`  input  1  bit qualifier; `sin` is sampled only on edges where `sin_en=1`.
- `frame`  input  1  start-of-word marker; meaningful only when `sin_en=1`.
- `clear`  input  1  synchronous clear of the sticky flags `overrun` and `frame_err`.
- `dout`  output  WIDTH  received word (holding register).
- `dout_valid`  output  1  `dout` holds an unconsumed word.
- `dout_ready`  input  1  consumer accepts `dout` on an edge where `dout_valid=1`.
- `busy`  output  1  a partial word is in progress (bit count nonzero).
- `overrun`  output  1  sticky: a completed word was dropped because the holding register was full.
- `frame_err`  output  1  sticky: `frame` arrived with a partial word in progress.

## Operation

Reset values: shift register=0, bit count=0, `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0.

Receive FSM, derived from the bit count `cnt` (width clog2(WIDTH+1)):
- IDLE (`cnt=0`): on `sin_en=1`, capture `sin` as bit 0 of a new word and go to RECV with `cnt=1`. `frame` may be 0 or 1 here; both are legal.
- RECV (`0<cnt<WIDTH`): on `sin_en=1` and `frame=0`, shift in `sin` and increment `cnt`.
- RECV with `sin_en=1` and `frame=1`: discard the partial word, set `frame_err`, capture `sin` as bit 0 of a new word, and set `cnt=1`.
- Word completion: when the edge captures bit `WIDTH`, `cnt` returns to 0 and the assembled word is offered to the holding register. This includes the degenerate case where the final bit arrives.
- `sin_en=0`: no change to the shift register or `cnt`; `frame` and `sin` are ignored.

Bit ordering:
- `MSB_FIRST=1`: shift left, new bit enters at the LSB. After `WIDTH` bits, the first bit is at `dout[WIDTH-1]`.
- `MSB_FIRST=0`: shift right, new bit enters at the MSB. After `WIDTH` bits, the first bit is at `dout[0]`.

Holding register and handshake:
- A completed word loads into `dout` and sets `dout_valid` if the register is empty (`dout_valid=0`), or if it is being consumed on the same edge (`dout_valid=1` and `dout_ready=1`).
- Otherwise the new word is dropped, `dout` keeps the old word, and `overrun` is set.
- Consume without a new completion: `dout_valid` falls to 0; `dout` retains its value.
- `dout` changes only on a load. It is stable while `dout_valid=1`.

Sticky flags:
- `overrun` and `frame_err` stay set until `clear=1` or `rst`.
- When `clear` coincides with a new error event, the flag ends set (set wins).

## Timing

- Input capture is on the same edge that `sin_en=1` is sampled. There are no combinational paths from inputs to outputs; all outputs are registered.
- Latency: `dout_valid` rises immediately after the edge that captures the final bit. Minimum word period is `WIDTH` cycles with `sin_en` held high.
- Back-to-back words with `dout_ready` held at 1: one word is accepted every `WIDTH` cycles, with no gaps and no overrun.
- `busy` equals `cnt!=0`, registered, and is updated on the same edge as `cnt`.
- Reset mid-word: all state clears asynchronously. The next `sin_en` starts a fresh word.

## Test plan

- Basic receive (`WIDTH=4`, `MSB_FIRST=1`): bits 1,0,1,1 on 4 consecutive edges with `sin_en=1` -> `dout=4'hB` and `dout_valid=1` after the 4th edge; `busy` reads 1,1,1,0 after edges 1 to 4.
- LSB-first (`MSB_FIRST=0`): bits 1,0,1,1 -> `dout=4'hD`.
- Overrun: `dout_ready=0`, send words 0xA then 0x5 -> `dout` stays 0xA and `overrun=1`; pulse `clear` -> `overrun=0`.
- Simultaneous consume and complete: word 0x3 is held; the final bit of 0xC coincides with `dout_ready=1` -> `dout=0xC`, `dout_valid` stays 1, `overrun=0`.
- Resync: after bits 1,1 of a word, assert `frame` with bit 0, then send 1,1,0 -> `frame_err=1` and `dout=4'h6`; gaps with `sin_en=0` inserted mid-word do not change the result.
- Reset mid-word: assert `rst` after 2 bits -> all outputs are 0 immediately; a subsequent full word 0x9 is received correctly.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH qualified bits into a word
// held on a registered valid/ready output, with sticky overrun and framing flags.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             frame,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic             frame_err_r;

  state_t           state_s;
  logic             restart_s;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] word_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             word_done_s;
  logic             frame_evt_s;
  logic             load_s;
  logic             consume_s;
  logic             ovr_evt_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
    if (MSB_FIRST) begin
      shift_in = {base[WIDTH-2:0], b};
    end else begin
      shift_in = {b, base[WIDTH-1:1]};
    end
  endfunction

  assign state_s = (cnt_r == {CW{1'b0}}) ? IDLE : RECV;

  // Next shift/count state; a frame marker mid-word or an idle start begins from an empty word.
  always_comb begin
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    word_done_s = 1'b0;
    frame_evt_s = 1'b0;
    restart_s   = 1'b0;
    case (state_s)
      IDLE:    restart_s = 1'b1;
      RECV:    restart_s = frame;
      default: restart_s = 1'b1;
    endcase
    base_s    = restart_s ? {WIDTH{1'b0}} : shift_r;
    word_s    = shift_in(base_s, sin);
    cnt_inc_s = restart_s ? CNT_ONE : (cnt_r + CNT_ONE);
    if (sin_en) begin
      frame_evt_s = (state_s == RECV) && frame;
      shift_nxt_s = word_s;
      if (cnt_inc_s == CNT_FULL) begin
        word_done_s = 1'b1;
        cnt_nxt_s   = {CW{1'b0}};
      end else begin
        cnt_nxt_s   = cnt_inc_s;
      end
    end else begin
      shift_nxt_s = shift_r;
    end
  end

  assign consume_s = dout_valid_r & dout_ready;
  assign load_s    = word_done_s & (~dout_valid_r | dout_ready);
  assign ovr_evt_s = word_done_s & dout_valid_r & ~dout_ready;

  // Receive state, holding register and sticky flags (a new error wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r      <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      shift_r   <= shift_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= (cnt_nxt_s != {CW{1'b0}});
      if (load_s) begin
        dout_r       <= word_s;
        dout_valid_r <= 1'b1;
      end else if (consume_s) begin
        dout_valid_r <= 1'b0;
      end
      overrun_r   <= ovr_evt_s   | (overrun_r   & ~clear);
      frame_err_r <= frame_evt_s | (frame_err_r & ~clear);
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: MSB-first and LSB-first instances share stimulus;
// monitors compare each consumed word against hand-computed expectations.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic       frame = 1'b0;
  logic       clear = 1'b0;
  logic       dout_ready = 1'b1;
  logic [3:0] dout_m, dout_l;
  logic       dout_valid_m, dout_valid_l;
  logic       busy_m, busy_l;
  logic       overrun_m, overrun_l;
  logic       frame_err_m, frame_err_l;

  int tests = 0;
  int failed = 0;
  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame(frame), .clear(clear),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .busy(busy_m), .overrun(overrun_m), .frame_err(frame_err_m)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame(frame), .clear(clear),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .busy(busy_l), .overrun(overrun_l), .frame_err(frame_err_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each task is entered just after a rising edge and leaves just after the capturing edge.
  task automatic drive(input logic b, input logic f, input logic c);
    sin = b; sin_en = 1'b1; frame = f; clear = c;
    @(posedge clk); #1;
    sin_en = 1'b0; frame = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Sends w MSB-first on the wire; exp_l is what the LSB-first instance assembles.
  task automatic send_word(input logic [3:0] w, input logic [3:0] exp_l, input bit push);
    if (push) begin
      q_m.push_back(w);
      q_l.push_back(exp_l);
    end
    for (int i = 3; i >= 0; i--) drive(w[i], 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout_m"}, {28'd0, dout_m}, 32'd0);
    chk({tag, "_dout_l"}, {28'd0, dout_l}, 32'd0);
    chk({tag, "_flags_m"}, {27'd0, dout_valid_m, busy_m, overrun_m, frame_err_m, 1'b0}, 32'd0);
    chk({tag, "_flags_l"}, {27'd0, dout_valid_l, busy_l, overrun_l, frame_err_l, 1'b0}, 32'd0);
  endtask

  // Monitors: pop and compare whenever a word is consumed.
  always @(negedge clk) begin
    if (!rst && dout_valid_m && dout_ready) begin
      if (q_m.size() == 0) begin
        tests++; failed++;
        $display("FAIL msb_word: got %0h expected none", dout_m);
      end else begin
        chk("msb_word", {28'd0, dout_m}, {28'd0, q_m.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dout_valid_l && dout_ready) begin
      if (q_l.size() == 0) begin
        tests++; failed++;
        $display("FAIL lsb_word: got %0h expected none", dout_l);
      end else begin
        chk("lsb_word", {28'd0, dout_l}, {28'd0, q_l.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] busy_exp;
    logic [3:0] bits;
    // Reset state
    idle(2);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(1);

    // Basic receive 1,0,1,1 with busy tracking
    dout_ready = 1'b1;
    busy_exp = 4'b1110;
    bits = 4'b1011;
    q_m.push_back(4'hB);
    q_l.push_back(4'hD);
    for (int i = 0; i < 4; i++) begin
      drive(bits[3-i], 1'b0, 1'b0);
      chk("basic_busy", {31'd0, busy_m}, {31'd0, busy_exp[3-i]});
    end
    chk("basic_dout_m", {28'd0, dout_m}, 32'hB);
    chk("basic_dout_l", {28'd0, dout_l}, 32'hD);
    chk("basic_valid", {31'd0, dout_valid_m}, 32'd1);
    idle(2);

    // Back-to-back words with ready held high
    send_word(4'h7, 4'hE, 1'b1);
    send_word(4'h2, 4'h4, 1'b1);
    send_word(4'hE, 4'h7, 1'b1);
    idle(2);
    chk("b2b_overrun", {31'd0, overrun_m}, 32'd0);

    // Overrun: second word dropped while the first is held
    dout_ready = 1'b0;
    send_word(4'hA, 4'h5, 1'b1);
    send_word(4'h5, 4'hA, 1'b0);
    chk("ovr_dout_m", {28'd0, dout_m}, 32'hA);
    chk("ovr_dout_l", {28'd0, dout_l}, 32'h5);
    chk("ovr_flag", {31'd0, overrun_m}, 32'd1);
    chk("ovr_valid", {31'd0, dout_valid_m}, 32'd1);
    clear_pulse();
    chk("ovr_clear", {31'd0, overrun_m}, 32'd0);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    chk("consume_valid", {31'd0, dout_valid_m}, 32'd0);
    chk("consume_dout_kept", {28'd0, dout_m}, 32'hA);

    // Simultaneous consume of 0x3 and completion of 0xC
    send_word(4'h3, 4'hC, 1'b1);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    q_m.push_back(4'hC);
    q_l.push_back(4'h3);
    dout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    dout_ready = 1'b0;
    chk("simul_dout", {28'd0, dout_m}, 32'hC);
    chk("simul_valid", {31'd0, dout_valid_m}, 32'd1);
    chk("simul_overrun", {31'd0, overrun_m}, 32'd0);
    dout_ready = 1'b1;
    idle(2);

    // Resync with frame mid-word and sin_en gaps
    chk("pre_frame_err", {31'd0, frame_err_m}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("resync_busy", {31'd0, busy_m}, 32'd1);
    idle(2);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    q_m.push_back(4'h6);
    q_l.push_back(4'h6);
    drive(1'b0, 1'b0, 1'b0);
    chk("resync_frame_err", {31'd0, frame_err_l}, 32'd1);
    chk("resync_dout", {28'd0, dout_m}, 32'h6);
    idle(1);
    clear_pulse();
    chk("frame_err_clear", {31'd0, frame_err_m}, 32'd0);

    // Clear coinciding with a framing error: set wins
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("setwins_frame_err", {31'd0, frame_err_m}, 32'd1);
    q_m.push_back(4'h5);
    q_l.push_back(4'hA);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("setwins_dout", {28'd0, dout_m}, 32'h5);
    idle(2);

    // Reset mid-word clears everything immediately
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    idle(1);
    rst = 1'b0;
    idle(1);
    send_word(4'h9, 4'h9, 1'b1);
    chk("post_rst_dout_m", {28'd0, dout_m}, 32'h9);
    chk("post_rst_dout_l", {28'd0, dout_l}, 32'h9);
    idle(3);

    chk("queue_m_drained", q_m.size(), 32'd0);
    chk("queue_l_drained", q_l.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
